dmem_bus_adapter: RTL and testbench

- Sits directly downstream of the core datapath. It consumes the ALU result (address), the store data and the decoder's mem_read/mem_write strobes.
- It runs each access as a req/ack transaction on a variable-latency data-memory bus and returns the load data on dmem_read_data.
- It asserts stall so the top level can hold the PC and register-file write enables until the access completes.
- It also detects misaligned and illegal accesses and bus timeouts, recording them in sticky fault state.

---
 rtl/dmem_bus_adapter.sv | 164 ++++++++++++++++
 tb/tb_dmem_bus_adapter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_adapter.sv
// Data-memory bus adapter: turns core load/store strobes into req/ack bus
// transactions, stalls the core while the bus is busy, and records alignment,
// illegal-strobe and timeout faults in sticky state.
module dmem_bus_adapter #(
  parameter int unsigned TIMEOUT    = 16,
  parameter logic [31:0] FAULT_DATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] dmem_read_data,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  input  logic        fault_clear,
  output logic        fault,
  output logic [31:0] fault_addr
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic          r_fault;
  logic [31:0]   r_fault_addr;

  logic          w_any;
  logic          w_va;
  logic          w_ba;
  logic          w_idle;
  logic          w_bus;
  logic          w_term;
  logic          w_timeout;
  logic          w_new_fault;
  logic [31:0]   w_fault_src;

  assign w_any       = mem_read | mem_write;
  assign w_va        = (mem_read ^ mem_write) && (addr[1:0] == 2'b00);
  assign w_ba        = (mem_read & mem_write) || (w_any && (addr[1:0] != 2'b00));
  assign w_idle      = (r_state == IDLE);
  assign w_bus       = (r_state == BUS);
  assign w_term      = (r_cnt == TERM);
  // A same-cycle ack beats the terminal count, so only ack-less expiry aborts.
  assign w_timeout   = w_bus && !bus_ack && w_term;
  assign w_new_fault = (w_idle && w_ba) || w_timeout;
  assign w_fault_src = w_idle ? addr : r_addr;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode plus core stall and bus request outputs.
  always_comb begin
    w_next  = r_state;
    stall   = 1'b0;
    bus_req = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_va) begin
          stall  = 1'b1;
          w_next = BUS;
        end
      end
      BUS: begin
        stall   = 1'b1;
        bus_req = 1'b1;
        if (bus_ack || w_term) begin
          w_next = DONE;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Transaction latches, timeout counter and load-data register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_va) begin
            r_addr  <= {addr[31:2], 2'b00};
            r_wdata <= write_data;
            r_we    <= mem_write;
            r_cnt   <= '0;
          end else if (w_ba) begin
            r_rdata <= FAULT_DATA;
          end
        end
        BUS: begin
          if (bus_ack) begin
            if (!r_we) begin
              r_rdata <= bus_rdata;
            end
          end else if (w_term) begin
            r_rdata <= FAULT_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Sticky fault flag; the first fault address is kept unless a clear
  // coincides with the new fault, in which case the new fault takes over.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
    end else if (w_new_fault) begin
      r_fault <= 1'b1;
      if (!r_fault || fault_clear) begin
        r_fault_addr <= w_fault_src;
      end
    end else if (fault_clear) begin
      r_fault <= 1'b0;
    end
  end

  assign dmem_read_data = r_rdata;
  assign bus_we         = r_we;
  assign bus_addr       = r_addr;
  assign bus_wdata      = r_wdata;
  assign fault          = r_fault;
  assign fault_addr     = r_fault_addr;

endmodule

// File: tb/tb_dmem_bus_adapter.sv
// Directed bench for dmem_bus_adapter, built with TIMEOUT=4.
module tb_dmem_bus_adapter;

  logic        clk;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] dmem_read_data;
  logic        stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        fault_clear;
  logic        fault;
  logic [31:0] fault_addr;

  int n_vec = 0;
  int n_err = 0;

  dmem_bus_adapter #(
    .TIMEOUT   (4),
    .FAULT_DATA(32'h0000_0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .addr          (addr),
    .write_data    (write_data),
    .dmem_read_data(dmem_read_data),
    .stall         (stall),
    .bus_req       (bus_req),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_ack       (bus_ack),
    .bus_rdata     (bus_rdata),
    .fault_clear   (fault_clear),
    .fault         (fault),
    .fault_addr    (fault_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one valid access from an IDLE cycle to its DONE cycle; acks on the
  // ack_at-th request cycle (0 = never). Returns in the DONE cycle.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input int ack_at,
                           input logic [31:0] rdv, input logic [31:0] exp_baddr,
                           output int n_stall, output int n_req,
                           output logic stable_ok);
    n_stall   = 0;
    n_req     = 0;
    stable_ok = 1'b1;
    mem_read   = rd;
    mem_write  = wr;
    addr       = a;
    write_data = wd;
    #1;
    for (int k = 0; k < 40; k++) begin
      if (!stall) break;
      n_stall++;
      if (bus_req) begin
        n_req++;
        if (bus_addr !== exp_baddr || bus_we !== wr) stable_ok = 1'b0;
        if (wr && bus_wdata !== wd) stable_ok = 1'b0;
        if (n_req == ack_at) begin
          bus_ack   = 1'b1;
          bus_rdata = rdv;
        end
      end
      @(posedge clk);
      #1;
      bus_ack   = 1'b0;
      bus_rdata = 32'h0;
      #1;
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    #1;
  endtask

  // Drives one bad access for a single cycle; reports stall/bus_req seen.
  task automatic bad_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic clr, output logic st, output logic rq);
    mem_read    = rd;
    mem_write   = wr;
    addr        = a;
    fault_clear = clr;
    #1;
    st = stall;
    rq = bus_req;
    @(posedge clk);
    #1;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    fault_clear = 1'b0;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (bus_req !== 1'b0 || bus_we !== 1'b0 || fault !== 1'b0 || stall !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got req=%b we=%b fault=%b stall=%b expected all 0",
               bus_req, bus_we, fault, stall);
    end
    n_vec++;
    if (bus_addr !== 32'h0 || bus_wdata !== 32'h0 || dmem_read_data !== 32'h0 || fault_addr !== 32'h0) begin
      n_err++;
      $display("FAIL reset_data: got baddr=%h wdata=%h rdata=%h faddr=%h expected all 0",
               bus_addr, bus_wdata, dmem_read_data, fault_addr);
    end
    reset = 1'b0;
    // ack in IDLE must be ignored
    bus_ack   = 1'b1;
    bus_rdata = 32'hDEAD_0001;
    next_cycle();
    bus_ack = 1'b0;
    n_vec++;
    if (dmem_read_data !== 32'h0 || bus_req !== 1'b0) begin
      n_err++;
      $display("FAIL idle_ack: got rdata=%h req=%b expected 00000000 0", dmem_read_data, bus_req);
    end
    // start a load, then reset in the middle of BUS
    mem_read = 1'b1;
    addr     = 32'h0000_0104;
    next_cycle();
    n_vec++;
    if (bus_req !== 1'b1) begin
      n_err++;
      $display("FAIL reset_setup_req: got %b expected 1", bus_req);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if (bus_req !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async_req: got %b expected 0", bus_req);
    end
    mem_read = 1'b0;
    next_cycle();
    reset     = 1'b0;
    bus_ack   = 1'b1;
    bus_rdata = 32'hDEAD_BEEF;
    next_cycle();
    bus_ack = 1'b0;
    #1;
    n_vec++;
    if (bus_req !== 1'b0 || stall !== 1'b0 || fault !== 1'b0 || dmem_read_data !== 32'h0) begin
      n_err++;
      $display("FAIL reset_late_ack: got req=%b stall=%b fault=%b rdata=%h expected 0 0 0 00000000",
               bus_req, stall, fault, dmem_read_data);
    end
  endtask

  task automatic test_load();
    int ns, nr;
    logic ok;
    do_access(1'b1, 1'b0, 32'h0000_0104, 32'h0, 3, 32'hCAFE_F00D, 32'h0000_0104, ns, nr, ok);
    n_vec++;
    if (ns !== 4 || nr !== 3) begin
      n_err++;
      $display("FAIL load_cycles: got stall=%0d req=%0d expected 4 3", ns, nr);
    end
    n_vec++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL load_bus_stable: got %b expected 1", ok);
    end
    n_vec++;
    if (stall !== 1'b0 || bus_req !== 1'b0 || dmem_read_data !== 32'hCAFE_F00D) begin
      n_err++;
      $display("FAIL load_done: got stall=%b req=%b rdata=%h expected 0 0 cafef00d",
               stall, bus_req, dmem_read_data);
    end
    next_cycle();
  endtask

  task automatic test_store();
    int ns, nr;
    logic ok;
    do_access(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 1, 32'h5555_5555, 32'h0000_0020, ns, nr, ok);
    n_vec++;
    if (ns !== 2 || nr !== 1) begin
      n_err++;
      $display("FAIL store_cycles: got stall=%0d req=%0d expected 2 1", ns, nr);
    end
    n_vec++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL store_bus_fields: got %b expected 1", ok);
    end
    n_vec++;
    if (dmem_read_data !== 32'hCAFE_F00D || fault !== 1'b0 || stall !== 1'b0) begin
      n_err++;
      $display("FAIL store_done: got rdata=%h fault=%b stall=%b expected cafef00d 0 0",
               dmem_read_data, fault, stall);
    end
    next_cycle();
  endtask

  task automatic test_timeout();
    int ns, nr;
    logic ok;
    do_access(1'b1, 1'b0, 32'h0000_0200, 32'h0, 0, 32'h0, 32'h0000_0200, ns, nr, ok);
    n_vec++;
    if (ns !== 5 || nr !== 4) begin
      n_err++;
      $display("FAIL timeout_cycles: got stall=%0d req=%0d expected 5 4", ns, nr);
    end
    n_vec++;
    if (dmem_read_data !== 32'h0 || fault !== 1'b1 || fault_addr !== 32'h0000_0200) begin
      n_err++;
      $display("FAIL timeout_fault: got rdata=%h fault=%b faddr=%h expected 00000000 1 00000200",
               dmem_read_data, fault, fault_addr);
    end
    next_cycle();
    fault_clear = 1'b1;
    next_cycle();
    fault_clear = 1'b0;
    n_vec++;
    if (fault !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_clear: got %b expected 0", fault);
    end
    // ack on the terminal-count cycle wins
    do_access(1'b1, 1'b0, 32'h0000_0300, 32'h0, 4, 32'hA5A5_5A5A, 32'h0000_0300, ns, nr, ok);
    n_vec++;
    if (ns !== 5 || nr !== 4 || dmem_read_data !== 32'hA5A5_5A5A || fault !== 1'b0) begin
      n_err++;
      $display("FAIL terminal_ack: got stall=%0d req=%0d rdata=%h fault=%b expected 5 4 a5a55a5a 0",
               ns, nr, dmem_read_data, fault);
    end
    next_cycle();
  endtask

  task automatic test_misaligned();
    logic st, rq;
    bad_access(1'b1, 1'b0, 32'h0000_0042, 1'b0, st, rq);
    n_vec++;
    if (st !== 1'b0 || rq !== 1'b0) begin
      n_err++;
      $display("FAIL misalign_nostall: got stall=%b req=%b expected 0 0", st, rq);
    end
    n_vec++;
    if (fault !== 1'b1 || fault_addr !== 32'h0000_0042 || dmem_read_data !== 32'h0 || bus_req !== 1'b0) begin
      n_err++;
      $display("FAIL misalign_fault: got fault=%b faddr=%h rdata=%h req=%b expected 1 00000042 00000000 0",
               fault, fault_addr, dmem_read_data, bus_req);
    end
    bad_access(1'b0, 1'b1, 32'h0000_0081, 1'b0, st, rq);
    n_vec++;
    if (fault !== 1'b1 || fault_addr !== 32'h0000_0042 || st !== 1'b0) begin
      n_err++;
      $display("FAIL misalign_sticky: got fault=%b faddr=%h stall=%b expected 1 00000042 0",
               fault, fault_addr, st);
    end
  endtask

  task automatic test_fault_clear();
    logic st, rq;
    bad_access(1'b1, 1'b0, 32'h0000_0013, 1'b1, st, rq);
    n_vec++;
    if (fault !== 1'b1 || fault_addr !== 32'h0000_0013) begin
      n_err++;
      $display("FAIL clear_collision: got fault=%b faddr=%h expected 1 00000013", fault, fault_addr);
    end
    fault_clear = 1'b1;
    next_cycle();
    fault_clear = 1'b0;
    n_vec++;
    if (fault !== 1'b0) begin
      n_err++;
      $display("FAIL clear_alone: got %b expected 0", fault);
    end
    // both strobes on an aligned address is illegal
    bad_access(1'b1, 1'b1, 32'h0000_0040, 1'b0, st, rq);
    n_vec++;
    if (st !== 1'b0 || rq !== 1'b0 || fault !== 1'b1 || fault_addr !== 32'h0000_0040) begin
      n_err++;
      $display("FAIL both_strobes: got stall=%b req=%b fault=%b faddr=%h expected 0 0 1 00000040",
               st, rq, fault, fault_addr);
    end
  endtask

  initial begin
    reset       = 1'b1;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    addr        = 32'h0;
    write_data  = 32'h0;
    bus_ack     = 1'b0;
    bus_rdata   = 32'h0;
    fault_clear = 1'b0;
    test_reset();
    test_load();
    test_store();
    test_timeout();
    test_misaligned();
    test_fault_clear();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
